// File: rtl/result_requant_pkg.sv
// Shared constants, config struct, FSM states and output entry for result_requant.
// No logic; no latency.
// No flow control here; the stream handshake lives in the top and the FIFO.
package result_requant_pkg;

    localparam int ACC_WIDTH  = 32;
    localparam int K_CHANNELS = 6;
    localparam int MAX_LINE_W = 32;
    localparam int OUT_WIDTH  = 8;
    localparam int SHIFT_W    = 5;
    localparam int FIFO_DEPTH = 4;

    localparam int CH_W  = $clog2(K_CHANNELS);
    localparam int COL_W = $clog2(MAX_LINE_W);
    localparam int LEN_W = $clog2(MAX_LINE_W + 1);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [SHIFT_W-1:0] shift;
        logic               relu_en;
    } requant_cfg_t;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } state_t;

    typedef struct packed {
        logic [OUT_WIDTH-1:0] data;
        logic [CH_W-1:0]      ch;
        logic [COL_W-1:0]     col;
        logic                 last;
    } out_entry_t;

endpackage

// File: rtl/result_out_fifo.sv
// Synchronous FIFO holding requantised output entries, with occupancy count.
// Write-to-head latency 1 cycle; head is visible combinationally.
// No internal backpressure: the caller keeps pushes within free space.
module result_out_fifo #(
    parameter int  WIDTH = 8,
    parameter int  DEPTH = 4,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [DEPTH-1:0][WIDTH-1:0] mem_q;
    logic [PW-1:0]               wr_ptr_q;
    logic [PW-1:0]               rd_ptr_q;
    logic [CW-1:0]               count_q;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Storage is reset so the head reads zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_dat;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (!push && pop) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    assign pop_dat = mem_q[rd_ptr_q];
    assign empty   = (count_q == '0);
    assign count   = count_q;

endmodule

// File: rtl/result_requant.sv
// Drains one output line from the result memories, requantises each value to int8 and streams it out.
// Start to first valid is 3 cycles; 1 element/cycle with ready held high.
// Reads are credit-gated so in-flight reads plus FIFO entries never exceed FIFO_DEPTH.
module result_requant
    import result_requant_pkg::*;
(
    input  logic                                 clk_i,
    input  logic                                 rst_async_n_i,
    input  logic                                 start_i,
    input  logic [LEN_W-1:0]                     line_len_i,
    input  logic [SHIFT_W-1:0]                   shift_i,
    input  logic                                 relu_en_i,
    input  logic [K_CHANNELS-1:0][ACC_WIDTH-1:0] bias_i,
    output logic                                 mem_rd_en_o,
    output logic [CH_W-1:0]                      mem_rd_ch_o,
    output logic [COL_W-1:0]                     mem_rd_addr_o,
    input  logic [ACC_WIDTH-1:0]                 mem_rd_data_i,
    output logic                                 out_valid_o,
    input  logic                                 out_ready_i,
    output logic [OUT_WIDTH-1:0]                 out_data_o,
    output logic [CH_W-1:0]                      out_ch_o,
    output logic [COL_W-1:0]                     out_col_o,
    output logic                                 out_last_o,
    output logic                                 busy_o,
    output logic                                 done_o
);

    // Two guard bits: one for bias add, one for the rounding increment.
    localparam int SW = ACC_WIDTH + 2;
    localparam logic signed [SW-1:0] SAT_MAX = SW'((2 ** (OUT_WIDTH - 1)) - 1);
    localparam logic signed [SW-1:0] SAT_MIN = SW'(-(2 ** (OUT_WIDTH - 1)));

    state_t                               state_q;
    requant_cfg_t                         cfg_q;
    logic [K_CHANNELS-1:0][ACC_WIDTH-1:0] bias_q;
    logic [COL_W-1:0]                     last_col_q;
    logic [CH_W-1:0]                      rd_ch_q;
    logic [COL_W-1:0]                     rd_col_q;
    logic                                 busy_q;
    logic                                 done_q;

    logic                                 pend_vld_q;
    logic [CH_W-1:0]                      pend_ch_q;
    logic [COL_W-1:0]                     pend_col_q;
    logic                                 pend_last_q;

    logic [CNT_W-1:0]                     fifo_count;
    logic                                 fifo_empty;
    logic                                 fifo_pop;
    out_entry_t                           push_entry;
    out_entry_t                           head_entry;

    logic                                 credit_ok;
    logic                                 rd_issue;
    logic                                 rd_last;
    logic                                 drain_done;

    logic [ACC_WIDTH-1:0]                 bias_sel;
    logic signed [SW-1:0]                 acc_ext;
    logic signed [SW-1:0]                 bias_ext;
    logic signed [SW-1:0]                 sum;
    logic signed [SW-1:0]                 rnd;
    logic signed [SW-1:0]                 shifted;
    logic signed [SW-1:0]                 rectified;
    logic signed [SW-1:0]                 clamped;

    // Credit uses only registered state so the read strobe has no path from out_ready_i.
    assign credit_ok  = ({1'b0, fifo_count} + (CNT_W + 1)'(pend_vld_q)) < (CNT_W + 1)'(FIFO_DEPTH);
    assign rd_issue   = (state_q == READ) && credit_ok;
    assign rd_last    = (rd_ch_q == CH_W'(K_CHANNELS - 1)) && (rd_col_q == last_col_q);
    assign fifo_pop   = out_valid_o && out_ready_i;
    // Leaving DRAIN on the final pop lets done_o land the cycle after acceptance.
    assign drain_done = !pend_vld_q &&
                        ((fifo_count == '0) || ((fifo_count == CNT_W'(1)) && fifo_pop));

    always_ff @(posedge clk_i or negedge rst_async_n_i) begin
        if (!rst_async_n_i) begin
            state_q    <= IDLE;
            cfg_q      <= '0;
            bias_q     <= '0;
            last_col_q <= '0;
            rd_ch_q    <= '0;
            rd_col_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        rd_ch_q  <= '0;
                        rd_col_q <= '0;
                        if (line_len_i != '0) begin
                            cfg_q      <= '{shift: shift_i, relu_en: relu_en_i};
                            bias_q     <= bias_i;
                            last_col_q <= COL_W'(line_len_i - 1'b1);
                            busy_q     <= 1'b1;
                            state_q    <= READ;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                READ: begin
                    if (rd_issue) begin
                        if (rd_last) begin
                            state_q <= DRAIN;
                        end else if (rd_col_q == last_col_q) begin
                            rd_col_q <= '0;
                            rd_ch_q  <= rd_ch_q + 1'b1;
                        end else begin
                            rd_col_q <= rd_col_q + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_done) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Tag of the read issued last cycle, aligned with its returning data.
    always_ff @(posedge clk_i or negedge rst_async_n_i) begin
        if (!rst_async_n_i) begin
            pend_vld_q  <= 1'b0;
            pend_ch_q   <= '0;
            pend_col_q  <= '0;
            pend_last_q <= 1'b0;
        end else begin
            pend_vld_q <= rd_issue;
            if (rd_issue) begin
                pend_ch_q   <= rd_ch_q;
                pend_col_q  <= rd_col_q;
                pend_last_q <= rd_last;
            end
        end
    end

    assign bias_sel = bias_q[pend_ch_q];

    always_comb begin
        acc_ext  = {{2{mem_rd_data_i[ACC_WIDTH-1]}}, mem_rd_data_i};
        bias_ext = {{2{bias_sel[ACC_WIDTH-1]}}, bias_sel};
        sum      = acc_ext + bias_ext;
        rnd      = sum;
        if (cfg_q.shift != '0) begin
            rnd = sum + (SW'(1) << (cfg_q.shift - 1'b1));
        end
        shifted   = rnd >>> cfg_q.shift;
        rectified = shifted;
        if (cfg_q.relu_en && shifted[SW-1]) begin
            rectified = '0;
        end
        clamped = rectified;
        if (rectified > SAT_MAX) begin
            clamped = SAT_MAX;
        end else if (rectified < SAT_MIN) begin
            clamped = SAT_MIN;
        end
        push_entry.data = clamped[OUT_WIDTH-1:0];
        push_entry.ch   = pend_ch_q;
        push_entry.col  = pend_col_q;
        push_entry.last = pend_last_q;
    end

    result_out_fifo #(
        .WIDTH($bits(out_entry_t)),
        .DEPTH(FIFO_DEPTH)
    ) u_out_fifo (
        .clk      (clk_i),
        .rst_n    (rst_async_n_i),
        .push     (pend_vld_q),
        .push_dat (push_entry),
        .pop      (fifo_pop),
        .pop_dat  (head_entry),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign mem_rd_en_o   = rd_issue;
    assign mem_rd_ch_o   = rd_ch_q;
    assign mem_rd_addr_o = rd_col_q;
    assign out_valid_o   = !fifo_empty;
    assign out_data_o    = head_entry.data;
    assign out_ch_o      = head_entry.ch;
    assign out_col_o     = head_entry.col;
    assign out_last_o    = head_entry.last;
    assign busy_o        = busy_q;
    assign done_o        = done_q;

endmodule

// File: tb/tb_result_requant.sv
// Directed self-checking bench for result_requant with a one-cycle-latency memory model.
module tb_result_requant;
    import result_requant_pkg::*;

    logic                                 clk = 1'b0;
    logic                                 rst_n;
    logic                                 start;
    logic [LEN_W-1:0]                     line_len;
    logic [SHIFT_W-1:0]                   shift;
    logic                                 relu_en;
    logic [K_CHANNELS-1:0][ACC_WIDTH-1:0] bias;
    logic                                 mem_rd_en;
    logic [CH_W-1:0]                      mem_rd_ch;
    logic [COL_W-1:0]                     mem_rd_addr;
    logic [ACC_WIDTH-1:0]                 mem_rd_data;
    logic                                 out_valid;
    logic                                 out_ready;
    logic [OUT_WIDTH-1:0]                 out_data;
    logic [CH_W-1:0]                      out_ch;
    logic [COL_W-1:0]                     out_col;
    logic                                 out_last;
    logic                                 busy;
    logic                                 done;

    logic [ACC_WIDTH-1:0] mem [K_CHANNELS][MAX_LINE_W];

    int checks = 0;
    int errors = 0;

    out_entry_t q_out[$];
    int         q_cyc[$];
    int         done_cyc;
    int         first_rd_cyc;
    int         first_rd_ch;
    int         first_rd_col;
    int         stall_viol;
    int         max_out;
    logic       busy_c1;
    logic       busy_at_done;

    result_requant dut (
        .clk_i         (clk),
        .rst_async_n_i (rst_n),
        .start_i       (start),
        .line_len_i    (line_len),
        .shift_i       (shift),
        .relu_en_i     (relu_en),
        .bias_i        (bias),
        .mem_rd_en_o   (mem_rd_en),
        .mem_rd_ch_o   (mem_rd_ch),
        .mem_rd_addr_o (mem_rd_addr),
        .mem_rd_data_i (mem_rd_data),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .out_data_o    (out_data),
        .out_ch_o      (out_ch),
        .out_col_o     (out_col),
        .out_last_o    (out_last),
        .busy_o        (busy),
        .done_o        (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_rd_ch][mem_rd_addr];
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not end, time %0t required < 500000", $time);
        $fatal(1);
    end

    function automatic out_entry_t mk(input int d, input int ch, input int col, input bit last);
        out_entry_t e;
        e.data = OUT_WIDTH'(d);
        e.ch   = CH_W'(ch);
        e.col  = COL_W'(col);
        e.last = last;
        return e;
    endfunction

    task automatic fill_basic();
        for (int k = 0; k < K_CHANNELS; k++)
            for (int c = 0; c < MAX_LINE_W; c++)
                mem[k][c] = ACC_WIDTH'(10 * k + c);
    endtask

    // Leaves the caller at the sampling point of cycle 1 (start sampled at edge 0).
    task automatic start_line(input int len, input int sh, input bit relu);
        @(negedge clk);
        line_len = LEN_W'(len);
        shift    = SHIFT_W'(sh);
        relu_en  = relu;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Records accepted elements and timing; ready_mode 1 drives 1,0,0,1 repeating.
    task automatic collect(input int ready_mode, input int restart_cyc, input int stop_after, input int max_cycles);
        int         cyc = 1;
        int         issued = 0;
        int         accepted = 0;
        bit         prev_stall = 0;
        out_entry_t prev_ent = '0;
        out_entry_t cur;
        q_out.delete();
        q_cyc.delete();
        done_cyc     = -1;
        first_rd_cyc = -1;
        first_rd_ch  = -1;
        first_rd_col = -1;
        stall_viol   = 0;
        max_out      = 0;
        busy_c1      = 1'bx;
        busy_at_done = 1'bx;
        while (cyc <= max_cycles) begin
            start = (cyc == restart_cyc);
            if (cyc == restart_cyc) line_len = LEN_W'(2);
            if (cyc == 1) busy_c1 = busy;
            cur.data = out_data;
            cur.ch   = out_ch;
            cur.col  = out_col;
            cur.last = out_last;
            if (prev_stall && (!out_valid || cur !== prev_ent)) stall_viol++;
            if (mem_rd_en) begin
                issued++;
                if (first_rd_cyc < 0) begin
                    first_rd_cyc = cyc;
                    first_rd_ch  = int'(mem_rd_ch);
                    first_rd_col = int'(mem_rd_addr);
                end
            end
            if (done) begin
                done_cyc     = cyc;
                busy_at_done = busy;
                break;
            end
            out_ready = (ready_mode == 0) ? 1'b1 : ((((cyc - 1) % 4) == 0) || (((cyc - 1) % 4) == 3));
            if (out_valid && out_ready) begin
                q_out.push_back(cur);
                q_cyc.push_back(cyc);
                accepted++;
            end
            prev_stall = out_valid && !out_ready;
            prev_ent   = cur;
            if (issued - accepted > max_out) max_out = issued - accepted;
            if (stop_after > 0 && accepted == stop_after) break;
            @(negedge clk);
            cyc++;
        end
        start     = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        checks++;
        if (out_data !== '0) begin errors++; $display("FAIL reset_data: got %h expected 00", out_data); end
        checks++;
        if ({busy, done} !== 2'b00) begin errors++; $display("FAIL reset_busy_done: got %b expected 00", {busy, done}); end
        checks++;
        if ({mem_rd_en, mem_rd_ch, mem_rd_addr} !== '0) begin
            errors++; $display("FAIL reset_mem_rd: got %h expected 0", {mem_rd_en, mem_rd_ch, mem_rd_addr});
        end
        checks++;
        if ({out_ch, out_col, out_last} !== '0) begin
            errors++; $display("FAIL reset_out_tag: got %h expected 0", {out_ch, out_col, out_last});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        fill_basic();
        bias = '0;
        start_line(4, 0, 1'b0);
        collect(0, 0, 0, 200);
        checks++;
        if (first_rd_cyc !== 1 || first_rd_ch !== 0 || first_rd_col !== 0) begin
            errors++; $display("FAIL basic_first_read: got cyc %0d ch %0d col %0d expected cyc 1 ch 0 col 0", first_rd_cyc, first_rd_ch, first_rd_col);
        end
        checks++;
        if (busy_c1 !== 1'b1) begin errors++; $display("FAIL basic_busy_c1: got %b expected 1", busy_c1); end
        checks++;
        if (q_out.size() != 24) begin errors++; $display("FAIL basic_count: got %0d expected 24", q_out.size()); end
        for (int i = 0; i < q_out.size() && i < 24; i++) begin
            checks++;
            if (q_out[i] !== mk(10 * (i / 4) + (i % 4), i / 4, i % 4, i == 23)) begin
                errors++; $display("FAIL basic_entry[%0d]: got %h expected %h", i, q_out[i], mk(10 * (i / 4) + (i % 4), i / 4, i % 4, i == 23));
            end
        end
        checks++;
        if (q_cyc.size() != 24 || q_cyc[0] != 3 || q_cyc[23] != 26) begin
            errors++; $display("FAIL basic_out_cycles: got first %0d last %0d expected 3 and 26", (q_cyc.size() > 0) ? q_cyc[0] : -1, (q_cyc.size() > 23) ? q_cyc[23] : -1);
        end
        checks++;
        if (done_cyc != 27) begin errors++; $display("FAIL basic_done_cycle: got %0d expected 27", done_cyc); end
        checks++;
        if (busy_at_done !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done: got %b expected 0", busy_at_done); end
    endtask

    task automatic test_rounding();
        int exp_v[6] = '{96, 96, 97, -96, -1, 127};
        bias = '0;
        mem[0][0] = ACC_WIDTH'(383);
        mem[1][0] = ACC_WIDTH'(385);
        mem[2][0] = ACC_WIDTH'(386);
        mem[3][0] = ACC_WIDTH'(-383);
        mem[4][0] = ACC_WIDTH'(-3);
        mem[5][0] = 32'h7FFF_FFFF;
        bias[5]   = 32'h7FFF_FFFF;
        start_line(1, 2, 1'b0);
        collect(0, 0, 0, 100);
        checks++;
        if (q_out.size() != 6 || done_cyc < 0) begin
            errors++; $display("FAIL round_count: got %0d elements done %0d expected 6 and done", q_out.size(), done_cyc);
        end
        for (int i = 0; i < q_out.size() && i < 6; i++) begin
            checks++;
            if (q_out[i] !== mk(exp_v[i], i, 0, i == 5)) begin
                errors++; $display("FAIL round_entry[%0d]: got %h expected %h", i, q_out[i], mk(exp_v[i], i, 0, i == 5));
            end
        end
    endtask

    task automatic test_saturation();
        int in_v[6]  = '{1000, -1000, 127, 128, -128, -129};
        int exp_v[6] = '{127, -128, 127, 127, -128, -128};
        bias = '0;
        for (int k = 0; k < 6; k++) mem[k][0] = ACC_WIDTH'(in_v[k]);
        start_line(1, 0, 1'b0);
        collect(0, 0, 0, 100);
        checks++;
        if (q_out.size() != 6) begin errors++; $display("FAIL sat_count: got %0d expected 6", q_out.size()); end
        for (int i = 0; i < q_out.size() && i < 6; i++) begin
            checks++;
            if (q_out[i] !== mk(exp_v[i], i, 0, i == 5)) begin
                errors++; $display("FAIL sat_entry[%0d]: got %h expected %h", i, q_out[i], mk(exp_v[i], i, 0, i == 5));
            end
        end
    endtask

    task automatic test_bias_relu();
        int b_v[6]    = '{100, -10, 3, 0, -200, 5};
        int in_v[6]   = '{50, 4, -5, 7, 0, -3};
        int exp_on[6] = '{127, 0, 0, 7, 0, 2};
        int exp_off[6] = '{127, -6, -2, 7, -128, 2};
        for (int k = 0; k < 6; k++) begin
            bias[k]   = ACC_WIDTH'(b_v[k]);
            mem[k][0] = ACC_WIDTH'(in_v[k]);
        end
        start_line(1, 0, 1'b1);
        collect(0, 0, 0, 100);
        checks++;
        if (q_out.size() != 6) begin errors++; $display("FAIL relu_on_count: got %0d expected 6", q_out.size()); end
        for (int i = 0; i < q_out.size() && i < 6; i++) begin
            checks++;
            if (q_out[i] !== mk(exp_on[i], i, 0, i == 5)) begin
                errors++; $display("FAIL relu_on_entry[%0d]: got %h expected %h", i, q_out[i], mk(exp_on[i], i, 0, i == 5));
            end
        end
        start_line(1, 0, 1'b0);
        collect(0, 0, 0, 100);
        checks++;
        if (q_out.size() != 6) begin errors++; $display("FAIL relu_off_count: got %0d expected 6", q_out.size()); end
        for (int i = 0; i < q_out.size() && i < 6; i++) begin
            checks++;
            if (q_out[i] !== mk(exp_off[i], i, 0, i == 5)) begin
                errors++; $display("FAIL relu_off_entry[%0d]: got %h expected %h", i, q_out[i], mk(exp_off[i], i, 0, i == 5));
            end
        end
        bias = '0;
    endtask

    task automatic test_backpressure();
        fill_basic();
        bias = '0;
        start_line(4, 0, 1'b0);
        collect(1, 0, 0, 400);
        checks++;
        if (q_out.size() != 24) begin errors++; $display("FAIL bp_count: got %0d expected 24", q_out.size()); end
        for (int i = 0; i < q_out.size() && i < 24; i++) begin
            checks++;
            if (q_out[i] !== mk(10 * (i / 4) + (i % 4), i / 4, i % 4, i == 23)) begin
                errors++; $display("FAIL bp_entry[%0d]: got %h expected %h", i, q_out[i], mk(10 * (i / 4) + (i % 4), i / 4, i % 4, i == 23));
            end
        end
        checks++;
        if (stall_viol != 0) begin errors++; $display("FAIL bp_stable: got %0d unstable stalls expected 0", stall_viol); end
        checks++;
        if (max_out > FIFO_DEPTH) begin errors++; $display("FAIL bp_outstanding: got %0d expected <= %0d", max_out, FIFO_DEPTH); end
        checks++;
        if (q_cyc.size() != 24 || done_cyc != q_cyc[23] + 1) begin
            errors++; $display("FAIL bp_done_cycle: got %0d expected one after last accept", done_cyc);
        end
    endtask

    task automatic test_zero_len();
        start_line(0, 0, 1'b0);
        collect(0, 0, 0, 20);
        checks++;
        if (done_cyc != 1) begin errors++; $display("FAIL zero_done_cycle: got %0d expected 1", done_cyc); end
        checks++;
        if (q_out.size() != 0 || first_rd_cyc != -1) begin
            errors++; $display("FAIL zero_no_output: got %0d outputs first read %0d expected 0 and -1", q_out.size(), first_rd_cyc);
        end
        checks++;
        if (busy_c1 !== 1'b0) begin errors++; $display("FAIL zero_busy: got %b expected 0", busy_c1); end
    endtask

    task automatic test_ignored_start();
        int extra = 0;
        fill_basic();
        bias = '0;
        start_line(4, 0, 1'b0);
        collect(0, 5, 0, 200);
        checks++;
        if (q_out.size() != 24) begin errors++; $display("FAIL restart_count: got %0d expected 24", q_out.size()); end
        for (int i = 0; i < q_out.size() && i < 24; i++) begin
            checks++;
            if (q_out[i] !== mk(10 * (i / 4) + (i % 4), i / 4, i % 4, i == 23)) begin
                errors++; $display("FAIL restart_entry[%0d]: got %h expected %h", i, q_out[i], mk(10 * (i / 4) + (i % 4), i / 4, i % 4, i == 23));
            end
        end
        checks++;
        if (done_cyc != 27) begin errors++; $display("FAIL restart_done_cycle: got %0d expected 27", done_cyc); end
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            if (out_valid || busy || mem_rd_en) extra++;
        end
        checks++;
        if (extra != 0) begin errors++; $display("FAIL restart_quiet_after: got %0d active cycles expected 0", extra); end
    endtask

    task automatic test_reset_midline();
        fill_basic();
        bias = '0;
        start_line(4, 0, 1'b0);
        collect(0, 0, 7, 200);
        checks++;
        if (q_out.size() != 7) begin errors++; $display("FAIL rst_pre_count: got %0d expected 7", q_out.size()); end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_data, out_ch, out_col, out_last, busy, done, mem_rd_en, mem_rd_ch, mem_rd_addr} !== '0) begin
            errors++; $display("FAIL rst_async_zero: got %h expected 0",
                {out_valid, out_data, out_ch, out_col, out_last, busy, done, mem_rd_en, mem_rd_ch, mem_rd_addr});
        end
        @(negedge clk);
        rst_n = 1'b1;
        start_line(4, 0, 1'b0);
        collect(0, 0, 0, 200);
        checks++;
        if (q_out.size() != 24) begin errors++; $display("FAIL rst_rerun_count: got %0d expected 24", q_out.size()); end
        for (int i = 0; i < q_out.size() && i < 24; i++) begin
            checks++;
            if (q_out[i] !== mk(10 * (i / 4) + (i % 4), i / 4, i % 4, i == 23)) begin
                errors++; $display("FAIL rst_rerun_entry[%0d]: got %h expected %h", i, q_out[i], mk(10 * (i / 4) + (i % 4), i / 4, i % 4, i == 23));
            end
        end
        checks++;
        if (done_cyc != 27) begin errors++; $display("FAIL rst_rerun_done: got %0d expected 27", done_cyc); end
    endtask

    initial begin
        out_ready = 1'b1;
        start     = 1'b0;
        line_len  = '0;
        shift     = '0;
        relu_en   = 1'b0;
        bias      = '0;
        test_reset();
        test_basic();
        test_rounding();
        test_saturation();
        test_bias_relu();
        test_backpressure();
        test_zero_len();
        test_ignored_start();
        test_reset_midline();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
